// File: rtl/ws2812_pkg.sv
`timescale 1ns/1ps
// ws2812_pkg: WS2812 line timing in CLK_40 cycles and FSM state encoding,
// shared by the transmit master and the pixel-receive side.
package ws2812_pkg;

  localparam int T0H           = 16;    // '0' high time, 400 ns
  localparam int T1H           = 32;    // '1' high time, 800 ns
  localparam int BIT           = 50;    // full bit period, 1.25 us
  localparam int RESET         = 2400;  // latch low time, 60 us
  localparam int LED_COUNT_DEF = 1152;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t HIGH  = 2'd1;
  localparam state_t LOW   = 2'd2;
  localparam state_t LATCH = 2'd3;

  function automatic int high_cycles(input logic bit_val, input int t0h, input int t1h);
    return bit_val ? t1h : t0h;
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
`timescale 1ns/1ps
// ws2812_bit_encoder: byte shifter, bit index and phase down-counter; drives the
// registered DOUT from the FSM's next state so the pulse edges line up with state changes.
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int T0H_CYCLES   = T0H,
  parameter int T1H_CYCLES   = T1H,
  parameter int BIT_CYCLES   = BIT,
  parameter int RESET_CYCLES = RESET
) (
  input  logic       CLK_40,
  input  logic       reset_n,
  input  state_t     state,
  input  state_t     state_next,
  input  logic       load,
  input  logic [7:0] load_byte,
  output logic       phase_done,
  output logic       byte_last,
  output logic       DOUT
);

  localparam int CW = $clog2(RESET_CYCLES + 1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic [2:0]    idx_reg, idx_next;
  logic          dout_reg;

  // Counter loads hold (phase length - 1) so the phase ends on the cycle it reads zero.
  function automatic logic [CW-1:0] high_load(input logic b);
    return CW'(high_cycles(b, T0H_CYCLES, T1H_CYCLES) - 1);
  endfunction

  function automatic logic [CW-1:0] low_load(input logic b);
    return CW'(BIT_CYCLES - high_cycles(b, T0H_CYCLES, T1H_CYCLES) - 1);
  endfunction

  always_comb begin
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    idx_next   = idx_reg;
    if (load) begin
      shift_next = load_byte;
      idx_next   = 3'd0;
      cnt_next   = high_load(load_byte[7]);
    end else if (state_next == LATCH && state != LATCH) begin
      cnt_next = CW'(RESET_CYCLES - 1);
    end else if (state == HIGH && state_next == LOW) begin
      cnt_next = low_load(shift_reg[7]);
    end else if (state == LOW && state_next == HIGH) begin
      shift_next = {shift_reg[6:0], 1'b0};
      idx_next   = idx_reg + 3'd1;
      cnt_next   = high_load(shift_reg[6]);
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg   <= '0;
      shift_reg <= '0;
      idx_reg   <= '0;
      dout_reg  <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      idx_reg   <= idx_next;
      dout_reg  <= (state_next == HIGH);
    end
  end

  assign phase_done = (cnt_reg == '0);
  assign byte_last  = (idx_reg == 3'd7);
  assign DOUT       = dout_reg;

endmodule

// File: rtl/ws2812_master.sv
`timescale 1ns/1ps
// ws2812_master: valid/ready byte stream to WS2812 serial pulses, with chain latch on frame_end.
// Define WS2812_TX_AUTOLATCH_EN to also latch automatically after LED_COUNT*3 accepted bytes.
module ws2812_master
  import ws2812_pkg::*;
#(
  parameter int T0H_CYCLES   = T0H,
  parameter int T1H_CYCLES   = T1H,
  parameter int BIT_CYCLES   = BIT,
  parameter int RESET_CYCLES = RESET,
  parameter int LED_COUNT    = LED_COUNT_DEF
) (
  input  logic       CLK_40,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       frame_end,
  output logic       busy,
  output logic       frame_done,
  output logic       DOUT
);

  state_t state_reg, state_next;
  logic   ready_en_reg;
  logic   pending_reg, pending_next;
  logic   phase_done, byte_last, byte_final;
  logic   accept, auto_set;

  if (BIT_CYCLES <= T1H_CYCLES || T0H_CYCLES < 1 || RESET_CYCLES < BIT_CYCLES || LED_COUNT < 1)
  begin : g_bad_params
    $error("ws2812_master: illegal timing or LED_COUNT parameters");
  end

  ws2812_bit_encoder #(
    .T0H_CYCLES  (T0H_CYCLES),
    .T1H_CYCLES  (T1H_CYCLES),
    .BIT_CYCLES  (BIT_CYCLES),
    .RESET_CYCLES(RESET_CYCLES)
  ) u_enc (
    .CLK_40    (CLK_40),
    .reset_n   (reset_n),
    .state     (state_reg),
    .state_next(state_next),
    .load      (accept),
    .load_byte (tx_data),
    .phase_done(phase_done),
    .byte_last (byte_last),
    .DOUT      (DOUT)
  );

  assign byte_final = (state_reg == LOW) && phase_done && byte_last;

  // A frame_end in the same cycle always beats a byte offer, so the latch is never delayed.
  assign tx_ready = ready_en_reg && !pending_reg && !frame_end &&
                    ((state_reg == IDLE) || byte_final);
  assign accept   = tx_valid && tx_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (frame_end)   state_next = LATCH;
        else if (accept) state_next = HIGH;
      end
      HIGH: begin
        if (phase_done) state_next = LOW;
      end
      LOW: begin
        if (phase_done) begin
          if (!byte_last)                     state_next = HIGH;
          else if (pending_reg || frame_end) state_next = LATCH;
          else if (accept)                    state_next = HIGH;
          else                                state_next = IDLE;
        end
      end
      LATCH: begin
        if (phase_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pending_next = pending_reg;
    if (state_next == LATCH)
      pending_next = 1'b0;
    else if ((frame_end || auto_set) && state_reg != LATCH)
      pending_next = 1'b1;
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      ready_en_reg <= 1'b0;
      pending_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ready_en_reg <= 1'b1;
      pending_reg  <= pending_next;
    end
  end

  assign busy       = (state_reg != IDLE);
  assign frame_done = (state_reg == LATCH) && phase_done;

`ifdef WS2812_TX_AUTOLATCH_EN
  localparam int FRAME_BYTES = LED_COUNT * 3;
  localparam int BCW         = $clog2(FRAME_BYTES + 1);

  logic [BCW-1:0] byte_cnt_reg;

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n)
      byte_cnt_reg <= '0;
    else if (frame_done)
      byte_cnt_reg <= '0;
    else if (accept)
      byte_cnt_reg <= byte_cnt_reg + 1'b1;
  end

  // Raised on the accept that completes the frame; the latch then follows that byte.
  assign auto_set = accept && (byte_cnt_reg == BCW'(FRAME_BYTES - 1));
`else
  assign auto_set = 1'b0;
`endif

endmodule
